// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-address generator and the later address checks.
package pc_pkg;

    // ExcCode values shared with CP0 and the M-stage address checks
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_NONE = 5'd0;

    // Where the next fetch PC comes from; also handy for debug probes
    typedef enum logic [1:0] {
        SEQ  = 2'd0,
        BR   = 2'd1,
        ERET = 2'd2,
        EXC  = 2'd3
    } redir_e;

endpackage

// File: rtl/pc_range_chk.sv
// Combinational fetch/data address legality check: word alignment plus
// membership in [IM_BASE, IM_BASE + 4*IM_WORDS). The upper bound is built one
// bit wider than the address so it cannot wrap.
module pc_range_chk #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    IM_BASE  = ADDR_W'(32'h0000_3000),
    parameter int unsigned          IM_WORDS = 4096
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              illegal
);

    localparam logic [ADDR_W:0] LO   = {1'b0, IM_BASE};
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(IM_WORDS) << 2;
    localparam logic [ADDR_W:0] HI   = LO + SPAN;

    logic [ADDR_W:0] addr_x;

    // Misaligned or outside the legal window
    always_comb begin
        addr_x  = {1'b0, addr};
        illegal = (addr[1:0] != 2'b00) || (addr_x < LO) || (addr_x >= HI);
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator for the F stage: holds the fetch PC, picks the next
// PC (exception vector > eret EPC > buffered/live branch target > PC+4),
// flags AdEL on illegal fetch addresses and inserts bubbles after exc/eret.
// Optional feature: define PC_HIST_EN to add a 4-entry history of valid PCs
// with the hist_idx/hist_pc read port.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    RESET_VEC  = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0]    EXC_VEC    = ADDR_W'(32'h0000_4180),
    parameter logic [ADDR_W-1:0]    IM_BASE    = ADDR_W'(32'h0000_3000),
    parameter int unsigned          IM_WORDS   = 4096,
    parameter int unsigned          BUBBLE_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic [4:0]        exc_code,
    output logic              br_pending
`ifdef PC_HIST_EN
    ,
    input  logic [1:0]        hist_idx,
    output logic [ADDR_W-1:0] hist_pc
`endif
);

    localparam logic [2:0] BUB_LOAD = 3'(BUBBLE_CYC);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              pend_q, pend_d;
    logic [2:0]        cnt_q, cnt_d;

    redir_e            src;
    logic              hold;
    logic [ADDR_W-1:0] br_sel;
    logic              illegal;

    // Next-PC selection, branch buffering and bubble counting
    always_comb begin
        src    = SEQ;
        hold   = 1'b0;
        tgt_d  = tgt_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        // A live branch is younger than a buffered one, so it wins
        br_sel = br_valid ? br_target : tgt_q;

        if (exc_req) begin
            src    = EXC;
            pend_d = 1'b0;
            cnt_d  = BUB_LOAD;
        end else if (eret_req) begin
            src    = ERET;
            pend_d = 1'b0;
            cnt_d  = BUB_LOAD;
        end else if (stall) begin
            hold = 1'b1;
            if (br_valid) begin
                tgt_d  = br_target;
                pend_d = 1'b1;
            end
        end else begin
            if (cnt_q != 3'd0) begin
                cnt_d = cnt_q - 3'd1;
            end
            if (pend_q || br_valid) begin
                src    = BR;
                pend_d = 1'b0;
            end
        end

        unique case (src)
            EXC:     pc_d = EXC_VEC;
            ERET:    pc_d = epc;
            BR:      pc_d = br_sel;
            default: pc_d = pc_q + ADDR_W'(4);
        endcase
        if (hold) begin
            pc_d = pc_q;
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q   <= RESET_VEC;
            pend_q <= 1'b0;
            cnt_q  <= 3'd0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // Buffered branch target; only meaningful while pend_q is set
    always_ff @(posedge clk) begin
        tgt_q <= tgt_d;
    end

    pc_range_chk #(
        .ADDR_W   (ADDR_W),
        .IM_BASE  (IM_BASE),
        .IM_WORDS (IM_WORDS)
    ) u_range_chk (
        .addr    (pc_q),
        .illegal (illegal)
    );

    assign pc         = pc_q;
    assign pc_valid   = (cnt_q == 3'd0);
    assign br_pending = pend_q;
    assign exc_code   = (pc_valid && illegal) ? EXC_ADEL : EXC_NONE;

`ifdef PC_HIST_EN
    logic [ADDR_W-1:0] hist_q [4];
    logic [ADDR_W-1:0] hist_d [4];
    logic [1:0]        hptr_q, hptr_d;
    logic [1:0]        rd_ptr;

    // Record each valid PC as it retires from fetch on a non-stalled edge
    always_comb begin
        hist_d = hist_q;
        hptr_d = hptr_q;
        if (!stall && pc_valid) begin
            hist_d[hptr_q] = pc_q;
            hptr_d         = hptr_q + 2'd1;
        end
        rd_ptr  = hptr_q - 2'd1 - hist_idx;
        hist_pc = hist_q[rd_ptr];
    end

    // History storage, cleared on reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= '0;
            end
            hptr_q <= 2'd0;
        end else begin
            hist_q <= hist_d;
            hptr_q <= hptr_d;
        end
    end
`endif

endmodule
